// File: rtl/vector_mem_stage.sv
// rtl/vector_mem_stage.sv - vector memory stage, serialises 8 lanes over one data-memory word port
// Optional: define VMEM_GATHER_EN for per-lane gather/scatter addressing.
module vector_mem_stage #(
    parameter int N  = 20,
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_e,
    input  logic [7:0][N-1:0]   ALUOutE,
    input  logic [7:0][N-1:0]   WDE,
    input  logic                MemWriteE,
    input  logic                MemtoRegE,
    input  logic                RegWriteE,
    input  logic [3:0]          WA3E,
    output logic                stall,
    output logic [AW-1:0]       mem_addr,
    output logic [N-1:0]        mem_wd,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [N-1:0]        mem_rd,
    output logic [7:0][N-1:0]   RD,
    output logic [7:0][N-1:0]   ALUOut,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic [3:0]          WA3,
    output logic                cargar
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CAPT, S_STORE} state_t;

    state_t              state, state_n;
    logic [2:0]          k;
    logic                accept, done;
    logic [AW-1:0]       lane_addr;
    logic [7:0][N-1:0]   alu_q;
    logic [7:0][N-1:0]   wd_q;
    logic [6:0][N-1:0]   rd_buf;
    logic                regwrite_q, memtoreg_q;
    logic [3:0]          wa3_q;

`ifdef VMEM_GATHER_EN
    logic [7:0][AW-1:0]  addr_q;
    assign lane_addr = addr_q[k];
`else
    logic [AW-1:0]       base_q;
    assign lane_addr = base_q + AW'(k);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        stall    = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        accept   = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (valid_e) begin
                    accept = 1'b1;
                    if (MemWriteE)      state_n = S_STORE;
                    else if (MemtoRegE) state_n = S_LOAD;
                    else                done    = 1'b1;
                end
            end
            S_LOAD: begin
                stall    = 1'b1;
                mem_re   = 1'b1;
                mem_addr = lane_addr;
                if (k == 3'd7) state_n = S_CAPT;
            end
            S_CAPT: begin
                stall   = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            S_STORE: begin
                stall    = 1'b1;
                mem_we   = 1'b1;
                mem_addr = lane_addr;
                mem_wd   = wd_q[k];
                if (k == 3'd7) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k          <= '0;
            alu_q      <= '0;
            wd_q       <= '0;
            rd_buf     <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            wa3_q      <= '0;
`ifdef VMEM_GATHER_EN
            addr_q     <= '0;
`else
            base_q     <= '0;
`endif
            RD         <= '0;
            ALUOut     <= '0;
            RegWrite   <= 1'b0;
            MemtoReg   <= 1'b0;
            WA3        <= '0;
            cargar     <= 1'b0;
        end else begin
            cargar <= done;
            if (accept) begin
                k          <= '0;
                alu_q      <= ALUOutE;
                wd_q       <= WDE;
                regwrite_q <= RegWriteE;
                memtoreg_q <= MemtoRegE;
                wa3_q      <= WA3E;
`ifdef VMEM_GATHER_EN
                for (int i = 0; i < 8; i++) addr_q[i] <= ALUOutE[i][AW-1:0];
`else
                base_q     <= ALUOutE[0][AW-1:0];
`endif
            end
            if (state == S_LOAD || state == S_STORE) k <= k + 3'd1;
            // read data trails its strobe by one cycle, so it belongs to lane k-1
            if (state == S_LOAD && k != 3'd0) rd_buf[k - 3'd1] <= mem_rd;
            if (done) begin
                if (state == S_IDLE) begin
                    ALUOut   <= ALUOutE;
                    RD       <= '0;
                    RegWrite <= RegWriteE;
                    MemtoReg <= MemtoRegE;
                    WA3      <= WA3E;
                end else begin
                    ALUOut   <= alu_q;
                    RD       <= (state == S_CAPT) ? {mem_rd, rd_buf} : '0;
                    RegWrite <= regwrite_q;
                    MemtoReg <= memtoreg_q;
                    WA3      <= wa3_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_mem_stage.sv
// tb/tb_vector_mem_stage.sv - directed self-checking bench for vector_mem_stage
module tb_vector_mem_stage;
    localparam int N  = 20;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_e;
    logic [7:0][N-1:0] ALUOutE, WDE;
    logic              MemWriteE, MemtoRegE, RegWriteE;
    logic [3:0]        WA3E;
    logic              stall;
    logic [AW-1:0]     mem_addr;
    logic [N-1:0]      mem_wd;
    logic              mem_we, mem_re;
    logic [N-1:0]      mem_rd;
    logic [7:0][N-1:0] RD, ALUOut;
    logic              RegWrite, MemtoReg;
    logic [3:0]        WA3;
    logic              cargar;

    int n_checks = 0;
    int n_errors = 0;

    vector_mem_stage #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .valid_e(valid_e),
        .ALUOutE(ALUOutE), .WDE(WDE),
        .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .WA3E(WA3E), .stall(stall),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rd(mem_rd), .RD(RD), .ALUOut(ALUOut),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .WA3(WA3), .cargar(cargar)
    );

    always #5 clk = ~clk;

    logic [N-1:0]  mem [0:1023];
    logic [AW-1:0] rd_log[$];

    function automatic logic [N-1:0] pattern(input int a);
        return N'(a * 3 + 5);
    endfunction

    always @(posedge clk) begin
        if (mem_re) begin
            mem_rd <= mem[mem_addr];
            rd_log.push_back(mem_addr);
        end
        if (mem_we) mem[mem_addr] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_e   = 1'b0;
        MemWriteE = 1'b0;
        MemtoRegE = 1'b0;
        RegWriteE = 1'b0;
        WA3E      = 4'd0;
        ALUOutE   = '0;
        WDE       = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_mem_re"}, 32'(mem_re), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wd"}, 32'(mem_wd), 32'd0);
        check({tag, "_cargar"}, 32'(cargar), 32'd0);
    endtask

    initial begin
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] gaddr [8];
        bit            seen;

        for (int i = 0; i < 1024; i++) mem[i] = pattern(i);
        mem_rd = '0;
        idle_inputs();
        reset = 1'b0;
        #2;
        check_quiet("reset");
        check("reset_RD", 32'(RD[0]), 32'd0);
        check("reset_ALUOut", 32'(ALUOut[7]), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // single ALU op: completes one cycle after accept
        for (int i = 0; i < 8; i++) ALUOutE[i] = N'(i + 1);
        RegWriteE = 1'b1;
        WA3E      = 4'd5;
        valid_e   = 1'b1;
        tick();
        idle_inputs();
        check("alu_cargar", 32'(cargar), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        check("alu_WA3", 32'(WA3), 32'd5);
        check("alu_RegWrite", 32'(RegWrite), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("alu_ALUOut%0d", i), 32'(ALUOut[i]), 32'(i + 1));
            check($sformatf("alu_RD%0d", i), 32'(RD[i]), 32'd0);
        end
        tick();
        check("alu_cargar_pulse", 32'(cargar), 32'd0);

        // back-to-back ALU ops
        ALUOutE[0] = 20'h11111;
        WA3E       = 4'd2;
        valid_e    = 1'b1;
        tick();
        check("b2b_cargar_a", 32'(cargar), 32'd1);
        check("b2b_ALUOut_a", 32'(ALUOut[0]), 32'h11111);
        ALUOutE[0] = 20'h22222;
        WA3E       = 4'd3;
        tick();
        idle_inputs();
        check("b2b_cargar_b", 32'(cargar), 32'd1);
        check("b2b_ALUOut_b", 32'(ALUOut[0]), 32'h22222);
        check("b2b_WA3_b", 32'(WA3), 32'd3);
        tick();
        check("b2b_cargar_end", 32'(cargar), 32'd0);

        // unit-stride load wrapping at the top of the address space
        for (int i = 0; i < 8; i++) begin
`ifdef VMEM_GATHER_EN
            ALUOutE[i] = N'((12'h3FC + i) & 12'h3FF);
`else
            ALUOutE[i] = N'(20'h00055 + i);
`endif
        end
        ALUOutE[0] = 20'h003FC;
        MemtoRegE  = 1'b1;
        RegWriteE  = 1'b1;
        WA3E       = 4'd9;
        valid_e    = 1'b1;
        tick();
        idle_inputs();
        valid_e = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_addr = AW'(10'h3FC + i);
            check($sformatf("ld_stall_c%0d", i + 1), 32'(stall), 32'd1);
            check($sformatf("ld_re_c%0d", i + 1), 32'(mem_re), 32'd1);
            check($sformatf("ld_addr_c%0d", i + 1), 32'(mem_addr), 32'(exp_addr));
            check($sformatf("ld_RD_hold_c%0d", i + 1), 32'(RD[i]), 32'd0);
            check($sformatf("ld_cargar_c%0d", i + 1), 32'(cargar), 32'd0);
            tick();
        end
        check("ld_capt_stall", 32'(stall), 32'd1);
        check("ld_capt_re", 32'(mem_re), 32'd0);
        check("ld_capt_cargar", 32'(cargar), 32'd0);
        tick();
        valid_e = 1'b0;
        check("ld_cargar_c10", 32'(cargar), 32'd1);
        check("ld_stall_c10", 32'(stall), 32'd0);
        check("ld_WA3", 32'(WA3), 32'd9);
        check("ld_MemtoReg", 32'(MemtoReg), 32'd1);
        check("ld_ALUOut0", 32'(ALUOut[0]), 32'h003FC);
        for (int i = 0; i < 8; i++)
            check($sformatf("ld_RD%0d", i), 32'(RD[i]), 32'(pattern((10'h3FC + i) & 10'h3FF)));
        tick();
        check("ld_cargar_pulse", 32'(cargar), 32'd0);

        // store of eight lanes at 0x010
        for (int i = 0; i < 8; i++) begin
            ALUOutE[i] = N'(20'h00010 + i);
            WDE[i]     = N'(20'hA0000 + i);
        end
        MemWriteE = 1'b1;
        MemtoRegE = 1'b1;
        valid_e   = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("st_stall_c%0d", i + 1), 32'(stall), 32'd1);
            check($sformatf("st_we_c%0d", i + 1), 32'(mem_we), 32'd1);
            check($sformatf("st_addr_c%0d", i + 1), 32'(mem_addr), 32'h10 + 32'(i));
            check($sformatf("st_wd_c%0d", i + 1), 32'(mem_wd), 32'hA0000 + 32'(i));
            check($sformatf("st_cargar_c%0d", i + 1), 32'(cargar), 32'd0);
            tick();
        end
        check("st_cargar_c9", 32'(cargar), 32'd1);
        check("st_stall_c9", 32'(stall), 32'd0);
        check("st_we_c9", 32'(mem_we), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("st_RD%0d", i), 32'(RD[i]), 32'd0);
            check($sformatf("st_mem%0d", i), 32'(mem[16 + i]), 32'hA0000 + 32'(i));
        end
        tick();

        // reset in c5 of a load
        for (int i = 0; i < 8; i++) ALUOutE[i] = N'(20'h00100 + i);
        MemtoRegE = 1'b1;
        valid_e   = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        check("abort_re_c5", 32'(mem_re), 32'd1);
        reset = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_WA3", 32'(WA3), 32'd0);
        check("abort_ALUOut0", 32'(ALUOut[0]), 32'd0);
        tick(); tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (cargar || stall) seen = 1'b1;
            tick();
        end
        check("abort_no_cargar", 32'(seen), 32'd0);
        ALUOutE[0] = 20'h0BEEF;
        WA3E       = 4'd7;
        valid_e    = 1'b1;
        tick();
        idle_inputs();
        check("post_abort_cargar", 32'(cargar), 32'd1);
        check("post_abort_ALUOut", 32'(ALUOut[0]), 32'h0BEEF);
        check("post_abort_WA3", 32'(WA3), 32'd7);
        tick();

`ifdef VMEM_GATHER_EN
        gaddr = '{10'd7, 10'd3, 10'h3FF, 10'd0, 10'd9, 10'd9, 10'd1, 10'd2};
        for (int i = 0; i < 8; i++) ALUOutE[i] = N'(gaddr[i]);
        MemtoRegE = 1'b1;
        valid_e   = 1'b1;
        rd_log.delete();
        tick();
        idle_inputs();
        for (int i = 0; i < 9; i++) tick();
        check("gather_cargar", 32'(cargar), 32'd1);
        check("gather_reads", 32'(rd_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rd_log.size()) check($sformatf("gather_addr%0d", i), 32'(rd_log[i]), 32'(gaddr[i]));
            check($sformatf("gather_RD%0d", i), 32'(RD[i]), 32'(pattern(int'(gaddr[i]))));
        end
        tick();
`else
        gaddr = '{default: '0};
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
